sram_arbiter: RTL and testbench

- Sequences and shares the board's 8-bit asynchronous SRAM (21-bit address) between two requesters: the CPU/chipset bus (read/write) and the video fetch path (read-only).
- Sits between `system` and the SRAM pins.
- Generates registered, glitch-free `SRAM_WE_n` and the data-bus drive enable; the top-level tristate is built from `sram_dq_o` / `sram_dq_oe`.
- CE_n, OE_n and LB_n stay tied at top level.

---
 rtl/sram_arbiter_if.sv | 29 ++
 rtl/sram_arbiter.sv | 106 ++++++++++
 tb/tb_sram_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: CPU port, video port and SRAM pin signals of sram_arbiter.
interface sram_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_ack;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [DATA_W-1:0] sram_dq_i;
  logic [DATA_W-1:0] sram_dq_o;
  logic              sram_dq_oe;
  logic              SRAM_WE_n;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, sram_dq_i,
    output cpu_rdata, cpu_ack, vid_rdata, vid_ack, SRAM_ADDR, sram_dq_o, sram_dq_oe, SRAM_WE_n
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, sram_dq_i,
    input  cpu_rdata, cpu_ack, vid_rdata, vid_ack, SRAM_ADDR, sram_dq_o, sram_dq_oe, SRAM_WE_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares an async SRAM between CPU (rd/wr) and video (rd) with registered strobes.
// Define SRAM_ARB_VID_PRIO_EN for strict video priority instead of round-robin.
module sram_arbiter #(
  parameter int ADDR_W  = 21,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input logic           clk_100,
  input logic           reset,
  sram_arbiter_if.slave bus
);
  localparam int CW = $clog2((RD_WAIT > WR_WAIT ? RD_WAIT : WR_WAIT) + 1);
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              gnt_vid_q, gnt_vid_d, last_vid_q, last_vid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_o_q, dq_o_d, cpu_rdata_q, cpu_rdata_d, vid_rdata_q, vid_rdata_d;
  logic              we_n_q, we_n_d, oe_q, oe_d, cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d;
  logic              pick_vid;
`ifdef SRAM_ARB_VID_PRIO_EN
  assign pick_vid = bus.vid_req;
`else
  assign pick_vid = bus.vid_req & (~bus.cpu_req | ~last_vid_q);
`endif
  always_ff @(posedge clk_100 or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_vid_q   <= 1'b0;
      last_vid_q  <= 1'b0;
      addr_q      <= '0;
      dq_o_q      <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      we_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_vid_q   <= gnt_vid_d;
      last_vid_q  <= last_vid_d;
      addr_q      <= addr_d;
      dq_o_q      <= dq_o_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      we_n_q      <= we_n_d;
      oe_q        <= oe_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
    end
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_vid_d   = gnt_vid_q;
    last_vid_d  = last_vid_q;
    addr_d      = addr_q;
    dq_o_d      = dq_o_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    case (state_q)
      IDLE: if (bus.cpu_req || bus.vid_req) begin
        gnt_vid_d  = pick_vid;
        last_vid_d = pick_vid;
        addr_d     = pick_vid ? bus.vid_addr : bus.cpu_addr;
        if (!pick_vid && bus.cpu_we) begin
          state_d = WR_SETUP;
          dq_o_d  = bus.cpu_wdata;
        end else begin
          state_d = RD;
          cnt_d   = CW'(RD_WAIT - 1);
        end
      end
      RD: if (cnt_q == '0) begin
        state_d     = DONE;
        vid_rdata_d = gnt_vid_q ? bus.sram_dq_i : vid_rdata_q;
        cpu_rdata_d = gnt_vid_q ? cpu_rdata_q : bus.sram_dq_i;
      end else cnt_d = cnt_q - 1'b1;
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = CW'(WR_WAIT - 1);
      end
      WR_PULSE: if (cnt_q == '0) state_d = WR_HOLD; else cnt_d = cnt_q - 1'b1;
      WR_HOLD: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    we_n_d    = state_d != WR_PULSE;
    oe_d      = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
    cpu_ack_d = state_d == DONE && !gnt_vid_d;
    vid_ack_d = state_d == DONE && gnt_vid_d;
  end
  assign bus.SRAM_ADDR  = addr_q;
  assign bus.sram_dq_o  = dq_o_q;
  assign bus.sram_dq_oe = oe_q;
  assign bus.SRAM_WE_n  = we_n_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.vid_rdata  = vid_rdata_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.vid_ack    = vid_ack_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized scenarios for sram_arbiter checked against an SRAM model and access-level expectations.
module tb_sram_arbiter;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;
  logic clk, rst;
  int checks = 0, passes = 0;
  logic [7:0] sram [0:(1<<21)-1];
  logic [7:0] exp_mem [logic [20:0]];
  logic pre_en = 0;
  logic [20:0] pre_addr = '0;
  logic [7:0] pre_data = '0;
  sram_arbiter_if bus ();
  sram_arbiter #(.ADDR_W(21), .DATA_W(8), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clk_100(clk), .reset(rst), .bus(bus)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  always @(negedge clk) begin
    if (pre_en) sram[pre_addr] <= pre_data;
    else if (bus.SRAM_WE_n === 1'b0 && bus.sram_dq_oe === 1'b1) sram[bus.SRAM_ADDR] <= bus.sram_dq_o;
    bus.sram_dq_i <= sram[bus.SRAM_ADDR];
  end

  task automatic preload(input logic [20:0] a, input logic [7:0] v);
    @(posedge clk); #1;
    pre_addr = a; pre_data = v; pre_en = 1;
    @(negedge clk); #1;
    pre_en = 0;
    exp_mem[a] = v;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1;
    bus.cpu_req = 0; bus.vid_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic access(input bit vid, input bit we, input logic [20:0] a, input logic [7:0] d,
                        output int ack_k, output int we_low, output int oe_cyc, output bit stable,
                        output logic [7:0] rd);
    @(posedge clk); #1;
    if (vid) begin
      bus.vid_req = 1; bus.vid_addr = a;
    end else begin
      bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
    ack_k = -1; we_low = 0; oe_cyc = 0; stable = 1; rd = '0;
    for (int k = 0; k < 40 && ack_k < 0; k++) begin
      @(negedge clk);
      if (bus.SRAM_WE_n === 1'b0) we_low++;
      if (bus.SRAM_WE_n === 1'b0 && bus.sram_dq_oe !== 1'b1) stable = 0;
      if (bus.sram_dq_oe === 1'b1) begin
        oe_cyc++;
        if (bus.SRAM_ADDR !== a || bus.sram_dq_o !== d) stable = 0;
      end
      if ((vid ? bus.vid_ack : bus.cpu_ack) === 1'b1) begin
        ack_k = k;
        rd = vid ? bus.vid_rdata : bus.cpu_rdata;
        bus.vid_req = 0; bus.cpu_req = 0;
      end
    end
    if (we) exp_mem[a] = d;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.SRAM_WE_n !== 1'b1) $display("FAIL reset_we_n: got %b want 1", bus.SRAM_WE_n); else passes++;
    checks++; if (bus.sram_dq_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", bus.sram_dq_oe); else passes++;
    checks++; if (bus.SRAM_ADDR !== 21'h0) $display("FAIL reset_addr: got %h want 0", bus.SRAM_ADDR); else passes++;
    checks++; if (bus.sram_dq_o !== 8'h0) $display("FAIL reset_dq_o: got %h want 0", bus.sram_dq_o); else passes++;
    checks++; if ({bus.cpu_rdata, bus.vid_rdata} !== 16'h0) $display("FAIL reset_rdata: got %h want 0", {bus.cpu_rdata, bus.vid_rdata}); else passes++;
    checks++; if ({bus.cpu_ack, bus.vid_ack} !== 2'b00) $display("FAIL reset_ack: got %b want 00", {bus.cpu_ack, bus.vid_ack}); else passes++;
  endtask

  task automatic test_write_read();
    logic [20:0] a; logic [7:0] d, rd; int ack_k, wl, oc; bit st;
    for (int i = 0; i < 3; i++) begin
      a = (i == 0) ? 21'h1ABCD : {5'd1, 16'($urandom)};
      d = (i == 0) ? 8'h5A : 8'($urandom);
      access(0, 1, a, d, ack_k, wl, oc, st, rd);
      checks++; if (ack_k != WR_WAIT + 3) $display("FAIL wr_ack_latency: got %0d want %0d", ack_k, WR_WAIT + 3); else passes++;
      checks++; if (wl != WR_WAIT) $display("FAIL wr_we_low: got %0d want %0d", wl, WR_WAIT); else passes++;
      checks++; if (oc != WR_WAIT + 2) $display("FAIL wr_oe_cycles: got %0d want %0d", oc, WR_WAIT + 2); else passes++;
      checks++; if (!st) $display("FAIL wr_stable: got unstable addr/data want stable"); else passes++;
      checks++; if (sram[a] !== d) $display("FAIL wr_mem: got %h want %h", sram[a], d); else passes++;
      access(0, 0, a, 8'h00, ack_k, wl, oc, st, rd);
      checks++; if (ack_k != RD_WAIT + 1) $display("FAIL rd_ack_latency: got %0d want %0d", ack_k, RD_WAIT + 1); else passes++;
      checks++; if (rd !== exp_mem[a]) $display("FAIL rd_data: got %h want %h", rd, exp_mem[a]); else passes++;
    end
  endtask

  task automatic test_video();
    logic [20:0] a; logic [7:0] v, rd, keep; int ack_k, wl, oc; bit st;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 21'h00010 : {5'd2, 16'($urandom)};
      v = (i == 0) ? 8'hC3 : 8'($urandom);
      preload(a, v);
      keep = bus.cpu_rdata;
      access(1, 0, a, 8'h00, ack_k, wl, oc, st, rd);
      checks++; if (ack_k != RD_WAIT + 1) $display("FAIL vid_ack_latency: got %0d want %0d", ack_k, RD_WAIT + 1); else passes++;
      checks++; if (rd !== v) $display("FAIL vid_rdata: got %h want %h", rd, v); else passes++;
      checks++; if (wl != 0 || oc != 0) $display("FAIL vid_no_drive: got we_low=%0d oe=%0d want 0/0", wl, oc); else passes++;
      checks++; if (bus.cpu_rdata !== keep) $display("FAIL vid_cpu_rdata_kept: got %h want %h", bus.cpu_rdata, keep); else passes++;
    end
  endtask

  task automatic test_round_robin();
    logic [20:0] ca, va; logic last_vid; logic exp_vid; int got;
    ca = {5'd3, 16'($urandom)};
    va = {5'd4, 16'($urandom)};
    preload(ca, 8'($urandom));
    preload(va, 8'($urandom));
    apply_reset();
    @(posedge clk); #1;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = ca;
    bus.vid_req = 1; bus.vid_addr = va;
    last_vid = 0; got = 0;
    for (int k = 0; k < 80 && got < 4; k++) begin
      @(negedge clk);
      if (bus.cpu_ack === 1'b1 || bus.vid_ack === 1'b1) begin
`ifdef SRAM_ARB_VID_PRIO_EN
        exp_vid = 1;
`else
        exp_vid = !last_vid;
`endif
        last_vid = exp_vid;
        checks++; if (bus.vid_ack !== exp_vid || bus.cpu_ack !== !exp_vid)
          $display("FAIL rr_grant%0d: got vid_ack=%b cpu_ack=%b want vid_ack=%b", got, bus.vid_ack, bus.cpu_ack, exp_vid); else passes++;
        checks++; if ((exp_vid ? bus.vid_rdata : bus.cpu_rdata) !== exp_mem[exp_vid ? va : ca])
          $display("FAIL rr_rdata%0d: got %h want %h", got, exp_vid ? bus.vid_rdata : bus.cpu_rdata, exp_mem[exp_vid ? va : ca]); else passes++;
        got++;
        if (got == 4) begin
          bus.cpu_req = 0; bus.vid_req = 0;
        end
      end
    end
    checks++; if (got != 4) $display("FAIL rr_ack_count: got %0d want 4", got); else passes++;
  endtask

  task automatic test_reset_mid_write();
    logic [20:0] a, b; logic [7:0] rd; int ack_k, wl, oc, acks; bit st, seen;
    a = {5'h10, 16'($urandom)};
    b = {5'd5, 16'($urandom)};
    preload(b, 8'($urandom));
    @(posedge clk); #1;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = a; bus.cpu_wdata = 8'($urandom);
    seen = 0; acks = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.cpu_ack === 1'b1) acks++;
      if (bus.SRAM_WE_n === 1'b0) seen = 1;
    end
    checks++; if (!seen) $display("FAIL rst_pulse_seen: got no WE_n pulse want one"); else passes++;
    #1 rst = 1;
    #1;
    checks++; if (bus.SRAM_WE_n !== 1'b1) $display("FAIL rst_async_we_n: got %b want 1", bus.SRAM_WE_n); else passes++;
    checks++; if (bus.sram_dq_oe !== 1'b0) $display("FAIL rst_async_oe: got %b want 0", bus.sram_dq_oe); else passes++;
    bus.cpu_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.cpu_ack === 1'b1) acks++;
    end
    checks++; if (acks != 0) $display("FAIL rst_no_ack: got %0d acks want 0", acks); else passes++;
    access(0, 0, b, 8'h00, ack_k, wl, oc, st, rd);
    checks++; if (ack_k != RD_WAIT + 1) $display("FAIL rst_then_read_latency: got %0d want %0d", ack_k, RD_WAIT + 1); else passes++;
    checks++; if (rd !== exp_mem[b]) $display("FAIL rst_then_read_data: got %h want %h", rd, exp_mem[b]); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [20:0] a; int acks[$];
    a = {5'd6, 16'($urandom)};
    preload(a, 8'($urandom));
    @(posedge clk); #1;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = a;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.cpu_ack === 1'b1) begin
        acks.push_back(k);
        checks++; if (bus.cpu_rdata !== exp_mem[a]) $display("FAIL b2b_rdata: got %h want %h", bus.cpu_rdata, exp_mem[a]); else passes++;
        if (acks.size() == 2) bus.cpu_req = 0;
      end
    end
    bus.cpu_req = 0;
    checks++; if (acks.size() != 2) $display("FAIL b2b_ack_count: got %0d want 2", acks.size()); else passes++;
    if (acks.size() == 2) begin
      checks++; if (acks[0] != RD_WAIT + 1) $display("FAIL b2b_first_ack: got %0d want %0d", acks[0], RD_WAIT + 1); else passes++;
      checks++; if (acks[1] - acks[0] != RD_WAIT + 2) $display("FAIL b2b_spacing: got %0d want %0d", acks[1] - acks[0], RD_WAIT + 2); else passes++;
    end
  endtask

  task automatic test_drop_req();
    logic [20:0] a; logic [7:0] d; int n, first;
    for (int w = 0; w < 2; w++) begin
      a = {5'd7, 16'($urandom)};
      d = 8'($urandom);
      preload(a, 8'($urandom));
      @(posedge clk); #1;
      bus.cpu_req = 1; bus.cpu_we = w[0]; bus.cpu_addr = a; bus.cpu_wdata = d;
      @(posedge clk); #1;
      bus.cpu_req = 0; bus.cpu_addr = ~a; bus.cpu_wdata = ~d; bus.cpu_we = ~w[0];
      if (w == 1) exp_mem[a] = d;
      n = 0; first = -1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus.cpu_ack === 1'b1) begin
          n++;
          if (first < 0) first = k;
        end
      end
      checks++; if (n != 1) $display("FAIL drop_ack_count_we%0d: got %0d want 1", w, n); else passes++;
      checks++; if (first != (w == 1 ? WR_WAIT + 2 : RD_WAIT)) $display("FAIL drop_ack_time_we%0d: got %0d want %0d", w, first, w == 1 ? WR_WAIT + 2 : RD_WAIT); else passes++;
      checks++; if ((w == 1 ? sram[a] : bus.cpu_rdata) !== exp_mem[a]) $display("FAIL drop_data_we%0d: got %h want %h", w, w == 1 ? sram[a] : bus.cpu_rdata, exp_mem[a]); else passes++;
    end
  endtask

  task automatic test_random();
    logic [20:0] pool [4]; logic [20:0] a; logic [7:0] d, rd, e; bit vid, we, st; int ack_k, wl, oc;
    for (int i = 0; i < 4; i++) begin
      pool[i] = {3'd0, 2'(i), 16'($urandom)};
      preload(pool[i], 8'($urandom));
    end
    repeat (16) begin
      vid = 1'($urandom_range(0, 1));
      we = !vid && 1'($urandom_range(0, 1));
      a = pool[$urandom_range(0, 3)];
      d = 8'($urandom);
      e = exp_mem[a];
      access(vid, we, a, we ? d : 8'h00, ack_k, wl, oc, st, rd);
      checks++; if (ack_k != (we ? WR_WAIT + 3 : RD_WAIT + 1)) $display("FAIL rand_latency vid=%b we=%b: got %0d want %0d", vid, we, ack_k, we ? WR_WAIT + 3 : RD_WAIT + 1); else passes++;
      checks++; if ((we ? sram[a] : rd) !== (we ? d : e)) $display("FAIL rand_data vid=%b we=%b addr=%h: got %h want %h", vid, we, a, we ? sram[a] : rd, we ? d : e); else passes++;
    end
  endtask

  initial begin
    rst = 1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vid_req = 0; bus.vid_addr = '0;
    test_reset();
    test_write_read();
    test_video();
    test_round_robin();
    test_reset_mid_write();
    test_back_to_back();
    test_drop_req();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
